// File: rtl/write_aligner.sv
// write_aligner: buffers byte-addressed writes and emits word-aligned RAM beats; ALIGN_STATS_EN adds split_cnt
module write_aligner #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_error,
  output logic              err_sticky,
  output logic              busy
`ifdef ALIGN_STATS_EN
  ,
  output logic [STAT_W-1:0] split_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fa_q [DEPTH];
  logic [31:0] fd_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic rdy_q, wr_q, err_q, split_q, split_d;
  logic [ADDR_W-1:0] addr_q, addr_d, b1a_q, b1a_d, ha, hbase;
  logic [31:0] data_q, data_d, b1d_q, b1d_d, hw;
  logic [3:0] be_q, be_d, b1b_q, b1b_d;
  logic [1:0] ho;
  logic push, pop, hs, load1;
  assign req_ready  = rdy_q;
  assign mem_wr_en  = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign mem_be     = be_q;
  assign err_sticky = err_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  // beat sequencing: pop the FIFO head into beat0, keep its beat1 parked until beat0 is accepted
  always_comb begin
    ha      = fa_q[rp_q];
    hw      = fd_q[rp_q];
    ho      = ha[1:0];
    hbase   = {ha[ADDR_W-1:2], 2'b00};
    push    = req_valid && rdy_q;
    hs      = wr_q && mem_ready;
    pop     = (cnt_q != '0) && (state_q == IDLE || (hs && (state_q == BEAT1 || !split_q)));
    load1   = hs && state_q == BEAT0 && split_q;
    state_d = pop ? BEAT0 : load1 ? BEAT1 : hs ? IDLE : state_q;
    addr_d  = pop ? hbase : load1 ? b1a_q : hs ? '0 : addr_q;
    data_d  = pop ? hw << {ho, 3'b000} : load1 ? b1d_q : hs ? '0 : data_q;
    be_d    = pop ? 4'(4'b1111 << ho) : load1 ? b1b_q : hs ? '0 : be_q;
    split_d = pop ? ho != 2'd0 : split_q;
    b1a_d   = pop ? hbase + ADDR_W'(4) : b1a_q;
    b1d_d   = pop ? hw >> {3'd4 - {1'b0, ho}, 3'b000} : b1d_q;
    b1b_d   = pop ? 4'b1111 >> (3'd4 - {1'b0, ho}) : b1b_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // control and beat registers; reset flushes the FIFO and drops any pending beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      b1a_q   <= '0;
      b1d_q   <= '0;
      b1b_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= push ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q   <= cnt_d;
      rdy_q   <= cnt_d != (PW+1)'(DEPTH);
      wr_q    <= state_d != IDLE;
      err_q   <= err_q || (hs && mem_error);
      split_q <= split_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      b1a_q   <= b1a_d;
      b1d_q   <= b1d_d;
      b1b_q   <= b1b_d;
    end
  end
  // FIFO storage, written only on an accepted request
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fa_q[wp_q] <= req_addr;
      fd_q[wp_q] <= req_wdata;
    end
  end
`ifdef ALIGN_STATS_EN
  logic [STAT_W-1:0] sc_q;
  // count split requests when their first beat is accepted, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) sc_q <= '0;
    else if (load1 && sc_q != '1) sc_q <= sc_q + 1'b1;
  end
  assign split_cnt = sc_q;
`endif
endmodule

// File: tb/tb_write_aligner.sv
// tb_write_aligner: directed checks of alignment, splitting, backpressure, reset and error capture
module tb_write_aligner;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready, mem_wr_en, mem_ready = 1'b0;
  logic mem_error = 1'b0, err_sticky, busy;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_addr, mem_wdata;
  logic [3:0] mem_be;
`ifdef ALIGN_STATS_EN
  logic [15:0] split_cnt;
`endif
  int n_cmp = 0, n_err = 0, idx;
  logic acc;

  write_aligner dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_wr_en(mem_wr_en),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_error(mem_error), .err_sticky(err_sticky), .busy(busy)
`ifdef ALIGN_STATS_EN
    , .split_cnt(split_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_en"}, mem_wr_en, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
    chk({tag, "_be"}, mem_be, be);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_busy", busy, 0);
    // aligned single beat
    mem_ready = 1'b1;
    push_one(32'h10, 32'hA1B2C3D4);
    chk("t1_lat_en", mem_wr_en, 0);
    chk("t1_busy", busy, 1);
    step();
    beat("t1", 32'h10, 32'hA1B2C3D4, 4'b1111);
    step();
    chk("t1_done_en", mem_wr_en, 0);
    chk("t1_done_busy", busy, 0);
    // offset-1 split
    push_one(32'h11, 32'hA1B2C3D4);
    step();
    beat("t2b0", 32'h10, 32'hB2C3D400, 4'b1110);
    step();
    beat("t2b1", 32'h14, 32'h000000A1, 4'b0001);
    step();
    chk("t2_done_en", mem_wr_en, 0);
`ifdef ALIGN_STATS_EN
    chk("t2_split_cnt", split_cnt, 1);
`endif
    // offset-3 split wrapping the address space
    push_one(32'hFFFFFFFF, 32'h11223344);
    step();
    beat("t3b0", 32'hFFFFFFFC, 32'h44000000, 4'b1000);
    step();
    beat("t3b1", 32'h00000000, 32'h00112233, 4'b0111);
    step();
    chk("t3_done_en", mem_wr_en, 0);
`ifdef ALIGN_STATS_EN
    chk("t3_split_cnt", split_cnt, 2);
`endif
    // backpressure: six offers, five fit (beat register + four FIFO entries)
    mem_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_addr  = 32'h100 + 32'(4 * idx);
      req_wdata = 32'hD0 + 32'(idx);
      acc = req_ready;
      step();
      if (acc) idx++;
    end
    chk("t4_accepted", idx, 5);
    chk("t4_ready_low", req_ready, 0);
    beat("t4_hold0", 32'h100, 32'hD0, 4'b1111);
    step();
    step();
    req_valid = 1'b0;
    chk("t4_ready_still_low", req_ready, 0);
    beat("t4_hold1", 32'h100, 32'hD0, 4'b1111);
    mem_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      beat($sformatf("t4_beat%0d", j), 32'h100 + 32'(4 * j), 32'hD0 + 32'(j), 4'b1111);
    end
    step();
    chk("t4_drained_en", mem_wr_en, 0);
    chk("t4_drained_busy", busy, 0);
    // reset while in BEAT1 with two requests queued
    mem_ready = 1'b0;
    push_one(32'h201, 32'hCAFEBABE);
    push_one(32'h300, 32'h1);
    push_one(32'h304, 32'h2);
    beat("t5b0", 32'h200, 32'hFEBABE00, 4'b1110);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    beat("t5b1", 32'h204, 32'h000000CA, 4'b0001);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_en", mem_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_addr", mem_addr, 0);
`ifdef ALIGN_STATS_EN
    chk("t5_split_cnt", split_cnt, 0);
`endif
    mem_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("t5_quiet%0d", j), mem_wr_en, 0);
    end
    // error capture on a beat handshake, held until reset
    push_one(32'h20, 32'h55);
    step();
    beat("t6b0", 32'h20, 32'h55, 4'b1111);
    chk("t6_err_pre", err_sticky, 0);
    mem_error = 1'b1;
    step();
    mem_error = 1'b0;
    chk("t6_err_set", err_sticky, 1);
    for (int j = 0; j < 3; j++) begin
      push_one(32'h40 + 32'(4 * j), 32'(j));
      step();
      step();
      chk($sformatf("t6_err_hold%0d", j), err_sticky, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_clear", err_sticky, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/write_aligner.md
Name: write_aligner

Overview:
Upstream front end for the aligned word RAM. It accepts byte-addressed 32-bit write requests on a valid/ready interface and buffers them in a small FIFO. Each request is converted into one or two word-aligned RAM writes with byte enables. As a result, the RAM only ever sees addresses with addr[1:0]==0; misaligned requests are split across two words instead of raising the RAM's alignment error.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
ADDR_W, 32, byte address width
STAT_W, 16, width of split counter (optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_addr  in  ADDR_W  byte address
req_wdata  in  32  write data, little-endian
mem_wr_en  out  1  RAM write valid
mem_ready  in  1  RAM accepts beat this cycle
mem_addr  out  ADDR_W  word address, [1:0] always 0
mem_wdata  out  32  shifted data; bytes with be=0 driven 0
mem_be  out  4  byte enables
mem_error  in  1  RAM error flag, sampled on beat handshake
err_sticky  out  1  set when mem_error seen on a handshake
busy  out  1  FIFO non-empty or beat pending
split_cnt  out  STAT_W  split counter (only with ALIGN_STATS_EN)

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; ports are clk and rst.
- Reset values: req_ready=1, mem_wr_en=0, mem_addr=0, mem_wdata=0, mem_be=0, err_sticky=0, busy=0, split_cnt=0.
- FIFO push: happens when req_valid&&req_ready.
- req_ready: registered, equal to !full computed from the count after the current edge.
- Full condition: no push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count is unchanged.
- Offset: o=addr[1:0]; base=addr&~3.
- o==0: single beat. addr=base, data=wdata, be=4'b1111.
- o!=0, beat0: addr=base, data=wdata<<(8*o), be=(4'b1111<<o)[3:0].
- o!=0, beat1: addr=base+4, modulo 2^ADDR_W (0xFFFFFFFC+4 wraps to 0), data=wdata>>(8*(4-o)), be=4'b1111>>(4-o).
- FSM states: IDLE, BEAT0, BEAT1.
- IDLE: if FIFO non-empty, pop the head and load the beat0 registers, then go to BEAT0.
- BEAT0: hold all mem_* stable while mem_ready=0. On handshake:
  - if split, load beat1 and go to BEAT1;
  - else if FIFO non-empty, pop and load the next beat0 (no bubble);
  - else go to IDLE.
- BEAT1: on handshake, if FIFO non-empty, pop and load beat0; else go to IDLE.
- mem_wr_en=1 exactly in BEAT0/BEAT1; all mem_* outputs are registered.
- Latency: a request accepted at edge N into an empty idle block drives mem_wr_en after edge N+1.
- Throughput: 1 beat/cycle with mem_ready held high.
- err_sticky: set on any handshake with mem_error=1; cleared only by rst.
- busy = (state!=IDLE) || (count!=0).
- Reset mid-operation: FIFO is flushed and the FSM goes to IDLE. Any pending beat, including a beat1 whose beat0 was already accepted, is discarded. mem_wr_en=0 after the reset edge.
- req_* inputs are ignored during rst.

Optional Feature:
- Macro: ALIGN_STATS_EN.
- Defined: port split_cnt exists. It increments by 1 on each beat0 handshake of a split request, saturates at all-ones, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Aligned single beat: push addr 0x00000010, data 0xA1B2C3D4, mem_ready=1 -> one beat: addr 0x10, data 0xA1B2C3D4, be 1111; mem_wr_en high exactly 1 cycle.
2. Offset-1 split: push addr 0x00000011, data 0xA1B2C3D4 -> beat0: 0x10, 0xB2C3D400, be 1110; then beat1: 0x14, 0x000000A1, be 0001. split_cnt=1.
3. Offset-3 wrap split: push addr 0xFFFFFFFF, data 0x11223344 -> beat0: 0xFFFFFFFC, 0x44000000, be 1000; beat1: 0x00000000, 0x00112233, be 0111.
4. Backpressure, DEPTH=4:
   - mem_ready=0; offer 6 aligned requests back-to-back -> 5 accepted (1 in the beat register, 4 in the FIFO); req_ready low from then; mem_* stable.
   - Release mem_ready -> 5 beats in order, one per cycle, no bubbles.
5. Reset mid-split: assert rst for 1 cycle while in BEAT1 with 2 FIFO entries -> mem_wr_en=0, busy=0, req_ready=1 after the edge; no further beats.
6. Error capture: mem_error=1 on the beat0 handshake of request addr 0x20 -> err_sticky=1 next cycle and held through 3 more requests until rst.
